// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the op input
//   seg_width()     : bits resolved per pipeline stage
//   params_ok()     : legality of a WIDTH/STAGES pair
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Segment width; guards the division so an illegal STAGES=0 still elaborates
  // far enough to hit the parameter check.
  function automatic int seg_width(input int width, input int stages);
    if (stages > 0) begin
      return width / stages;
    end else begin
      return width;
    end
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG-bit carry-chained slice of the pipelined adder (purely combinational).
//   a, b   : operand segments (b already inverted for subtract)
//   ci     : carry into the segment
//   s, co  : segment sum and carry out
//   a_msb, b_msb : top operand bits, used for signed overflow in the last slice
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           a_msb,
  output logic           b_msb
);

  logic [SEG:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s       = total_s[SEG-1:0];
  assign co      = total_s[SEG];
  assign a_msb   = a[SEG-1];
  assign b_msb   = b[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready on both sides.
// Each of STAGES stages resolves one SEG-bit segment using the carry registered
// by the previous stage. Operand bits not yet added travel down the pipe with
// their carry (skew), and resolved low sum bits travel alongside the remaining
// work (deskew), so the full result leaves aligned after STAGES cycles.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   in1, in2, cin, op   : operands, carry-in, 0 = add / 1 = subtract
//   out_valid/out_ready : output handshake
//   sum, cout, ovf      : result, carry-out of MSB, signed overflow
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  logic             en_s;
  logic [WIDTH-1:0] b_eff_s;

  // Effective B operand: inverted for subtract so one adder serves both ops
  always_comb begin
    if (op == OP_SUB) begin
      b_eff_s = ~in2;
    end else begin
      b_eff_s = in2;
    end
  end

  // The whole pipe advances together; it only stops when a result is waiting
  // and downstream refuses it. Bubbles advance like beats.
  assign en_s     = ~out_valid | out_ready;
  assign in_ready = en_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO_W = (k + 1) * SEG;   // sum bits resolved after this stage
    localparam int HI_W = WIDTH - LO_W;    // operand bits still to be added

    logic [SEG-1:0]  seg_a_s;
    logic [SEG-1:0]  seg_b_s;
    logic [SEG-1:0]  seg_s_s;
    logic            seg_ci_s;
    logic            seg_co_s;
    logic            valid_in_s;
    logic [LO_W-1:0] sum_in_s;
    logic            valid_r;
    logic            c_r;
    logic [LO_W-1:0] sum_r;

    if (k == 0) begin : g_src
      assign seg_a_s    = in1[SEG-1:0];
      assign seg_b_s    = b_eff_s[SEG-1:0];
      assign seg_ci_s   = cin;
      assign valid_in_s = in_valid;
      assign sum_in_s   = seg_s_s;
    end else begin : g_src
      // Lowest remaining operand segment of the previous stage is ours.
      assign seg_a_s    = g_stage[k-1].g_ops.a_r[SEG-1:0];
      assign seg_b_s    = g_stage[k-1].g_ops.b_r[SEG-1:0];
      assign seg_ci_s   = g_stage[k-1].c_r;
      assign valid_in_s = g_stage[k-1].valid_r;
      assign sum_in_s   = {seg_s_s, g_stage[k-1].sum_r};
    end

    if (k < STAGES - 1) begin : g_ops
      logic [HI_W-1:0] a_in_s;
      logic [HI_W-1:0] b_in_s;
      logic [HI_W-1:0] a_r;
      logic [HI_W-1:0] b_r;

      if (k == 0) begin : g_fwd
        assign a_in_s = in1[WIDTH-1:SEG];
        assign b_in_s = b_eff_s[WIDTH-1:SEG];
      end else begin : g_fwd
        assign a_in_s = g_stage[k-1].g_ops.a_r[HI_W+SEG-1:SEG];
        assign b_in_s = g_stage[k-1].g_ops.b_r[HI_W+SEG-1:SEG];
      end

      // Skew registers: unadded operand bits ride along with their carry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= {HI_W{1'b0}};
          b_r <= {HI_W{1'b0}};
        end else if (en_s) begin
          a_r <= a_in_s;
          b_r <= b_in_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic a_msb_s;
      logic b_msb_s;
      logic ovf_r;

      adder_segment #(.SEG(SEG)) u_seg (
        .a     (seg_a_s),
        .b     (seg_b_s),
        .ci    (seg_ci_s),
        .s     (seg_s_s),
        .co    (seg_co_s),
        .a_msb (a_msb_s),
        .b_msb (b_msb_s)
      );

      // Signed overflow: operands share a sign but the result's sign differs
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en_s) begin
          ovf_r <= (a_msb_s == b_msb_s) && (seg_s_s[SEG-1] != a_msb_s);
        end
      end
    end else begin : g_body
      logic unused_a_msb_s;
      logic unused_b_msb_s;

      adder_segment #(.SEG(SEG)) u_seg (
        .a     (seg_a_s),
        .b     (seg_b_s),
        .ci    (seg_ci_s),
        .s     (seg_s_s),
        .co    (seg_co_s),
        .a_msb (unused_a_msb_s),
        .b_msb (unused_b_msb_s)
      );
    end

    // Stage register: valid bit, carry and resolved low sum bits (deskew)
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        c_r     <= 1'b0;
        sum_r   <= {LO_W{1'b0}};
      end else if (en_s) begin
        valid_r <= valid_in_s;
        c_r     <= seg_co_s;
        sum_r   <= sum_in_s;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;

endmodule
